// File: rtl/keypad_matrix_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared encodings for the keypad matrix scanner: FSM states,
//               frame classes and default code widths for a 3x3 matrix.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package keypad_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_SINGLE = 2'd1,
      CLS_MULTI  = 2'd2
   } frame_class_t;

   localparam int DEFAULT_ROWS = 3;
   localparam int DEFAULT_COLS = 3;

   // Code widths for the default matrix: row index, column index, position.
   localparam int RW = $clog2(DEFAULT_ROWS);
   localparam int CW = $clog2(DEFAULT_COLS);
   localparam int PW = $clog2(DEFAULT_ROWS * DEFAULT_COLS);

endpackage
`default_nettype wire

// File: rtl/keypad_matrix_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scanner_if
// Description : Pin and event bundle between the keypad matrix, the scanner
//               (master) and the game-control logic / pins (slave).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface keypad_matrix_scanner_if
   import keypad_pkg::*;
#(
   parameter int ROWS = DEFAULT_ROWS,
   parameter int COLS = DEFAULT_COLS
) ();

   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);
   localparam int POS_W = $clog2(ROWS * COLS);

   logic [ROWS-1:0]        row;          // raw row pins, active-low
   logic [COLS-1:0]        column;       // column drive, active-low one-hot
   logic                   key_valid;
   logic                   key_release;
   logic                   key_down;
   logic [ROW_W+COL_W-1:0] key;          // {row index, column index}
   logic [POS_W-1:0]       position;     // row*COLS + col
   logic                   multi_key;
   logic                   key_repeat;

   modport master (
      input  row,
      output column, key_valid, key_release, key_down,
      output key, position, multi_key, key_repeat
   );

   modport slave (
      output row,
      input  column, key_valid, key_release, key_down,
      input  key, position, multi_key, key_repeat
   );

endinterface
`default_nettype wire

// File: rtl/keypad_matrix_scanner_scan_tick.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_tick
// Description : Column-slot divider. Produces a tick every SCAN_DIV cycles,
//               rotates the active column index and flags the last slot of
//               each frame.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module keypad_scan_tick #(
   parameter int COLS     = 3,
   parameter int SCAN_DIV = 5000,
   parameter int COL_W    = $clog2(COLS)
) (
   input  wire logic             clk,
   input  wire logic             reset,
   output logic                  tick,
   output logic [COL_W-1:0]      col_idx,
   output logic                  frame_end
);

   localparam int DIV_W = $clog2(SCAN_DIV);

   logic [DIV_W-1:0] r_div;
   logic [COL_W-1:0] r_col;

   assign tick      = (r_div == DIV_W'(SCAN_DIV - 1));
   assign col_idx   = r_col;
   assign frame_end = tick && (r_col == COL_W'(COLS - 1));

   // Slot divider: counts 0..SCAN_DIV-1 and wraps on the tick cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     r_div <= '0;
      else if (tick)  r_div <= '0;
      else            r_div <= r_div + DIV_W'(1);
   end

   // Column rotation: advance on every tick, wrapping after the last column.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           r_col <= '0;
      else if (frame_end)   r_col <= '0;
      else if (tick)        r_col <= r_col + COL_W'(1);
   end

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scanner
// Description : ROWS x COLS active-low keypad scanner with per-frame
//               debounce, ghost (multi-key) frame rejection and
//               press/release events.
//               Optional auto-repeat: define KEYPAD_AUTOREPEAT_EN.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS            = 3,
   parameter int COLS            = 3,
   parameter int SCAN_DIV        = 5000,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int REPEAT_DELAY    = 30,
   parameter int REPEAT_RATE     = 6
) (
   input  wire logic               clk,
   input  wire logic               reset,
   keypad_matrix_scanner_if.master bus
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);
   localparam int POS_W = $clog2(ROWS * COLS);
   localparam int NKEYS = ROWS * COLS;
   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

   if (ROWS < 2 || COLS < 2 || SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 ||
       REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
      $error("keypad_matrix_scanner: illegal parameter set");
   end

   logic               w_tick;
   logic               w_frame_end;
   logic [COL_W-1:0]   w_col_idx;

   logic [ROWS-1:0]    r_sync1, r_sync2;
   logic [NKEYS-1:0]   r_frame, w_frame_now;
   frame_class_t       w_class;
   logic [POS_W-1:0]   w_pos;

   state_t             r_state, w_state_next;
   logic [POS_W-1:0]   r_cand, w_cand_next;
   logic [CNT_W-1:0]   r_cnt, w_cnt_next, w_cnt_inc;
   logic [CNT_W-1:0]   r_rcnt, w_rcnt_next, w_rcnt_inc;
   logic [ROW_W+COL_W-1:0] r_key, w_key_next;
   logic [POS_W-1:0]   r_position, w_position_next;
   logic               r_key_down, w_down_next;
   logic               r_key_valid, w_valid_next;
   logic               r_key_release, w_release_next;
   logic               r_multi_key, w_multi_next;
   logic               w_accept;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int REP_W   = $clog2(REP_MAX + 1);
   logic [REP_W-1:0]   r_rep_cnt, w_rep_cnt_next, w_rep_inc;
   logic               r_rep_phase, w_rep_phase_next;   // 0: first delay, 1: rate
   logic               r_key_repeat, w_repeat_next;
`endif

   keypad_scan_tick #(
      .COLS     (COLS),
      .SCAN_DIV (SCAN_DIV),
      .COL_W    (COL_W)
   ) u_scan_tick (
      .clk       (clk),
      .reset     (reset),
      .tick      (w_tick),
      .col_idx   (w_col_idx),
      .frame_end (w_frame_end)
   );

   assign bus.column = ~(COLS'(1) << w_col_idx);

   // Two-flop row synchroniser, inverted so a pressed key reads as 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= ~bus.row;
         r_sync2 <= r_sync1;
      end
   end

   // Frame image including the column being sampled this cycle.
   always_comb begin
      w_frame_now = r_frame;
      for (int r = 0; r < ROWS; r++)
         w_frame_now[r*COLS + int'(w_col_idx)] = r_sync2[r];
   end

   // Frame accumulation: latch each column on its tick, clear at frame end.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)            r_frame <= '0;
      else if (w_frame_end)  r_frame <= '0;
      else if (w_tick)       r_frame <= w_frame_now;
   end

   // Frame classification: none / exactly one key (and which) / several.
   always_comb begin
      w_class = CLS_NONE;
      w_pos   = '0;
      for (int i = 0; i < NKEYS; i++) begin
         if (w_frame_now[i]) begin
            if (w_class == CLS_NONE) begin
               w_class = CLS_SINGLE;
               w_pos   = POS_W'(i);
            end else begin
               w_class = CLS_MULTI;
            end
         end
      end
   end

   assign w_cnt_inc  = r_cnt + CNT_W'(1);
   assign w_rcnt_inc = r_rcnt + CNT_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
   assign w_rep_inc  = r_rep_cnt + REP_W'(1);
`endif

   // State register and registered event outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_cand        <= '0;
         r_cnt         <= '0;
         r_rcnt        <= '0;
         r_key         <= '0;
         r_position    <= '0;
         r_key_down    <= 1'b0;
         r_key_valid   <= 1'b0;
         r_key_release <= 1'b0;
         r_multi_key   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         r_rep_cnt     <= '0;
         r_rep_phase   <= 1'b0;
         r_key_repeat  <= 1'b0;
`endif
      end else begin
         r_state       <= w_state_next;
         r_cand        <= w_cand_next;
         r_cnt         <= w_cnt_next;
         r_rcnt        <= w_rcnt_next;
         r_key         <= w_key_next;
         r_position    <= w_position_next;
         r_key_down    <= w_down_next;
         r_key_valid   <= w_valid_next;
         r_key_release <= w_release_next;
         r_multi_key   <= w_multi_next;
`ifdef KEYPAD_AUTOREPEAT_EN
         r_rep_cnt     <= w_rep_cnt_next;
         r_rep_phase   <= w_rep_phase_next;
         r_key_repeat  <= w_repeat_next;
`endif
      end
   end

   // Debounce / hold / release decisions, taken only at frame end.
   always_comb begin
      w_state_next    = r_state;
      w_cand_next     = r_cand;
      w_cnt_next      = r_cnt;
      w_rcnt_next     = r_rcnt;
      w_key_next      = r_key;
      w_position_next = r_position;
      w_down_next     = r_key_down;
      w_valid_next    = 1'b0;
      w_release_next  = 1'b0;
      w_multi_next    = 1'b0;
      w_accept        = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      w_rep_cnt_next   = r_rep_cnt;
      w_rep_phase_next = r_rep_phase;
      w_repeat_next    = 1'b0;
`endif
      if (w_frame_end) begin
         case (r_state)
            ST_IDLE: begin
               if (w_class == CLS_SINGLE) begin
                  w_cand_next = w_pos;
                  w_cnt_next  = CNT_W'(1);
                  if (DEBOUNCE_FRAMES == 1) w_accept     = 1'b1;
                  else                      w_state_next = ST_DEBOUNCE;
               end else if (w_class == CLS_MULTI) begin
                  w_multi_next = 1'b1;
               end
            end
            ST_DEBOUNCE: begin
               if (w_class == CLS_SINGLE && w_pos == r_cand) begin
                  w_cnt_next = w_cnt_inc;
                  if (w_cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) w_accept = 1'b1;
               end else begin
                  w_state_next = ST_IDLE;
                  w_multi_next = (w_class == CLS_MULTI);
               end
            end
            ST_HELD: begin
               // Only the held key matters; extra keys alongside it are ignored.
               if (!w_frame_now[r_position]) begin
                  if (w_rcnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
                     w_release_next = 1'b1;
                     w_down_next    = 1'b0;
                     w_rcnt_next    = '0;
                     w_state_next   = ST_IDLE;
                  end else begin
                     w_rcnt_next = w_rcnt_inc;
                  end
               end else begin
                  w_rcnt_next = '0;
               end
`ifdef KEYPAD_AUTOREPEAT_EN
               if (!w_release_next) begin
                  w_rep_cnt_next = w_rep_inc;
                  if (w_rep_inc == (r_rep_phase ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY))) begin
                     w_valid_next     = 1'b1;
                     w_repeat_next    = 1'b1;
                     w_rep_cnt_next   = '0;
                     w_rep_phase_next = 1'b1;
                  end
               end
`endif
            end
            default: w_state_next = ST_IDLE;
         endcase

         // Both accept paths have w_pos equal to the candidate.
         if (w_accept) begin
            w_key_next      = {ROW_W'(w_pos / POS_W'(COLS)), COL_W'(w_pos % POS_W'(COLS))};
            w_position_next = w_pos;
            w_down_next     = 1'b1;
            w_valid_next    = 1'b1;
            w_rcnt_next     = '0;
            w_state_next    = ST_HELD;
         end
`ifdef KEYPAD_AUTOREPEAT_EN
         if (w_accept || w_release_next) begin
            w_rep_cnt_next   = '0;
            w_rep_phase_next = 1'b0;
         end
`endif
      end
   end

   assign bus.key_valid   = r_key_valid;
   assign bus.key_release = r_key_release;
   assign bus.key_down    = r_key_down;
   assign bus.key         = r_key;
   assign bus.position    = r_position;
   assign bus.multi_key   = r_multi_key;
`ifdef KEYPAD_AUTOREPEAT_EN
   assign bus.key_repeat  = r_key_repeat;
`else
   assign bus.key_repeat  = 1'b0;
`endif

endmodule
`default_nettype wire
